// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end for sha256_core_v3: packs bytes into 512-bit blocks,
// appends padding and bit length, issues blocks to the core and captures the digest.
module sha256_msg_sequencer #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_start,
    output logic         core_first_run,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_hash,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: a byte transfers on every rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_data/in_last are only sampled then.
    typedef enum logic [1:0] {FILL = 2'd0, PAD = 2'd1, START = 2'd2, WAIT = 2'd3} state_t;
    typedef enum logic [1:0] {PEND_NONE = 2'd0, PEND_LEN = 2'd1, PEND_PADLEN = 2'd2} pend_t;

    state_t             state_q, state_d;
    pend_t              pend_q;
    logic [511:0]       buf_q;
    logic [6:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               first_q;
    logic               final_q;
    logic               arm_q;
    logic [255:0]       digest_q;
    logic               dv_q;
    logic               busy_q;
    logic               rdy_q;

    logic               accept;
    logic [63:0]        bit_len;
    logic [511:0]       wr_blk;
    logic [511:0]       pad_blk;

    assign accept = in_valid && rdy_q;

    always_comb begin
        bit_len = '0;
        bit_len[CNT_W+2:0] = {cnt_q, 3'b000};
    end

    always_comb begin
        wr_blk = buf_q;
        for (int i = 0; i < 64; i++) begin
            if (idx_q == 7'(i)) wr_blk[8*(63-i) +: 8] = in_data;
        end
    end

    // A full 64-byte final block gets no marker here; it moves to the pending block.
    always_comb begin
        pad_blk = buf_q;
        for (int i = 0; i < 64; i++) begin
            if (idx_q == 7'(i)) pad_blk[8*(63-i) +: 8] = 8'h80;
        end
        if (idx_q <= 7'd55) pad_blk[63:0] = bit_len;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_last) state_d = PAD;
                    else if (idx_q == 7'd63) state_d = START;
                end
            end
            PAD:   state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (arm_q && core_ready) state_d = (pend_q != PEND_NONE) ? START : FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            pend_q   <= PEND_NONE;
            final_q  <= 1'b0;
            arm_q    <= 1'b0;
            digest_q <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            rdy_q <= (state_d == FILL);
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        buf_q  <= wr_blk;
                        idx_q  <= idx_q + 7'd1;
                        cnt_q  <= cnt_q + 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                PAD: begin
                    buf_q <= pad_blk;
                    if (idx_q <= 7'd55) begin
                        final_q <= 1'b1;
                        pend_q  <= PEND_NONE;
                    end else if (idx_q <= 7'd63) begin
                        final_q <= 1'b0;
                        pend_q  <= PEND_LEN;
                    end else begin
                        final_q <= 1'b0;
                        pend_q  <= PEND_PADLEN;
                    end
                end
                START: begin
                    first_q <= 1'b0;
                    arm_q   <= 1'b0;
                end
                WAIT: begin
                    // ready is still high from the previous block until the core drops it
                    if (!core_ready) begin
                        arm_q <= 1'b1;
                    end else if (arm_q) begin
                        if (pend_q != PEND_NONE) begin
                            buf_q   <= (pend_q == PEND_LEN) ? {448'd0, bit_len}
                                                            : {8'h80, 440'd0, bit_len};
                            pend_q  <= PEND_NONE;
                            final_q <= 1'b1;
                        end else begin
                            buf_q <= '0;
                            idx_q <= '0;
                            if (final_q) begin
                                digest_q <= core_hash;
                                dv_q     <= 1'b1;
                                first_q  <= 1'b1;
                                cnt_q    <= '0;
                                busy_q   <= 1'b0;
                                final_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = rdy_q;
    assign core_start     = (state_q == START);
    assign core_first_run = (state_q == START) && first_q;
    assign core_block     = buf_q;
    assign digest         = digest_q;
    assign digest_valid   = dv_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core and
// an independent padding reference for whole-message digests.
module tb_sha256_msg_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         core_start;
    logic         core_first_run;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_hash;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic [1:0]   dbg_state;

    sha256_msg_sequencer #(.CNT_W(61)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .core_start(core_start), .core_first_run(core_first_run), .core_block(core_block),
        .core_ready(core_ready), .core_hash(core_hash),
        .digest(digest), .digest_valid(digest_valid), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] Q56_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    logic [7:0] msg [256];

    // Whole-message SHA-256 with padding built byte by byte from the message length.
    function automatic logic [255:0] ref_digest(input int len);
        logic [255:0] h;
        logic [511:0] blk;
        logic [63:0]  blen;
        int plen, gi;
        logic [7:0] v;
        h = IV;
        blen = 64'(len) * 64'd8;
        plen = ((len + 8) / 64 + 1) * 64;
        for (int bi = 0; bi < plen / 64; bi++) begin
            for (int j = 0; j < 64; j++) begin
                gi = bi * 64 + j;
                if (gi < len) v = msg[gi];
                else if (gi == len) v = 8'h80;
                else if (gi >= plen - 8) v = blen[8*(plen-1-gi) +: 8];
                else v = 8'h00;
                blk[511 - 8*j -: 8] = v;
            end
            h = compress(h, blk);
        end
        return h;
    endfunction

    // Core model: ready low 66 cycles after start (optionally delayed by lag), hash updates as ready rises.
    int           tmr;
    int           lag = 0;
    logic [255:0] hash_r, h_next;
    assign core_ready = (tmr == 0) || (tmr > 66);
    assign core_hash  = hash_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr    <= 0;
            hash_r <= '0;
            h_next <= '0;
        end else if (core_start) begin
            tmr    <= 66 + lag;
            h_next <= compress(core_first_run ? IV : hash_r, core_block);
        end else if (tmr > 0) begin
            tmr <= tmr - 1;
            if (tmr == 1) hash_r <= h_next;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor, sampled on the falling edge.
    int          cyc = 0;
    int          start_cnt = 0;
    int          dv_cnt = 0;
    int          proto_err = 0;
    int          last_cyc = 0;
    int          dv_cyc = 0;
    logic [7:0]  fr_bits = '0;
    logic        prev_start = 1'b0;
    logic        prev_busy = 1'b0;
    logic [511:0] blk_q [$];
    int          start_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) begin
                start_cnt++;
                fr_bits = {fr_bits[6:0], core_first_run};
                blk_q.push_back(core_block);
                start_cyc_q.push_back(cyc);
                if (prev_start || tmr != 0) proto_err++;
            end
            if (in_ready && (core_start || tmr != 0)) proto_err++;
            if (in_valid && in_ready && in_last) last_cyc = cyc;
            if (digest_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
                if (busy || !prev_busy || !in_ready) proto_err++;
            end
            prev_start = core_start;
            prev_busy  = busy;
        end
    end

    task automatic send_msg(input int len, input bit last_flag);
        int t;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = last_flag && (i == len - 1);
            t = 0;
            forever begin
                @(negedge clk);
                t++;
                if (in_ready || t > 500) break;
            end
            if (t > 500) begin
                check_eq("accept_timeout", 512'(t), 512'd0);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_dv();
        int base;
        int t;
        base = dv_cnt;
        t = 0;
        while (dv_cnt == base && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (dv_cnt == base) check_eq("digest_timeout", 512'(t), 512'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_in_ready"}, 512'(in_ready), 512'd0);
        check_eq({pfx, "_core_start"}, 512'(core_start), 512'd0);
        check_eq({pfx, "_first_run"}, 512'(core_first_run), 512'd0);
        check_eq({pfx, "_core_block"}, core_block, 512'd0);
        check_eq({pfx, "_digest"}, 512'(digest), 512'd0);
        check_eq({pfx, "_digest_valid"}, 512'(digest_valid), 512'd0);
        check_eq({pfx, "_busy"}, 512'(busy), 512'd0);
    endtask

    int s0, b0, d0, t;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", 512'(in_ready), 512'd1);

        // "abc": single block, latency from last byte to digest
        load_str("abc");
        s0 = start_cnt;
        send_msg(3, 1'b1);
        wait_dv();
        check_eq("abc_digest", 512'(digest), 512'(ABC_DIGEST));
        check_eq("abc_starts", 512'(start_cnt - s0), 512'd1);
        check_eq("abc_first_run", 512'(fr_bits[0]), 512'd1);
        check_eq("abc_latency", 512'(dv_cyc - last_cyc), 512'd70);

        // 56-byte message: length-only second block
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        s0 = start_cnt;
        b0 = blk_q.size();
        send_msg(56, 1'b1);
        wait_dv();
        check_eq("q56_digest", 512'(digest), 512'(Q56_DIGEST));
        check_eq("q56_starts", 512'(start_cnt - s0), 512'd2);
        check_eq("q56_first_run", 512'(fr_bits[1:0]), 512'd2);
        if (blk_q.size() >= b0 + 2) begin
            check_eq("q56_block2", blk_q[b0+1], {448'd0, 64'h1c0});
            check_eq("q56_start_gap", 512'(start_cyc_q[b0+1] - start_cyc_q[b0]), 512'd68);
            check_eq("q56_dv_gap", 512'(dv_cyc - start_cyc_q[b0+1]), 512'd68);
        end else begin
            check_eq("q56_block_count", 512'(blk_q.size() - b0), 512'd2);
        end

        // 55 x 'a': padding fits in the same block
        for (int i = 0; i < 64; i++) msg[i] = 8'h61;
        s0 = start_cnt;
        send_msg(55, 1'b1);
        wait_dv();
        check_eq("a55_starts", 512'(start_cnt - s0), 512'd1);
        check_eq("a55_digest", 512'(digest), 512'(ref_digest(55)));

        // 64 x 'a': marker and length move to a second block
        s0 = start_cnt;
        b0 = blk_q.size();
        send_msg(64, 1'b1);
        wait_dv();
        check_eq("a64_starts", 512'(start_cnt - s0), 512'd2);
        if (blk_q.size() >= b0 + 2) check_eq("a64_block2", blk_q[b0+1], {8'h80, 440'd0, 64'h200});
        else check_eq("a64_block_count", 512'(blk_q.size() - b0), 512'd2);
        check_eq("a64_digest", 512'(digest), 512'(ref_digest(64)));

        // 200 bytes with in_valid held through every stall
        for (int i = 0; i < 200; i++) msg[i] = 8'(i * 7 + 3);
        s0 = start_cnt;
        send_msg(200, 1'b1);
        wait_dv();
        check_eq("m200_starts", 512'(start_cnt - s0), 512'd4);
        check_eq("m200_first_run", 512'(fr_bits[3:0]), 512'h8);
        check_eq("m200_digest", 512'(digest), 512'(ref_digest(200)));

        // Back-to-back with core ready lingering high after each start
        lag = 3;
        load_str("abc");
        d0 = dv_cnt;
        send_msg(3, 1'b1);
        wait_dv();
        check_eq("b2b_digest1", 512'(digest), 512'(ABC_DIGEST));
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        send_msg(56, 1'b1);
        wait_dv();
        check_eq("b2b_digest2", 512'(digest), 512'(Q56_DIGEST));
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_dv_count", 512'(dv_cnt - d0), 512'd2);
        check_eq("b2b_digest_held", 512'(digest), 512'(Q56_DIGEST));
        lag = 0;

        // Reset while waiting on the core mid-message
        for (int i = 0; i < 64; i++) msg[i] = 8'h78;
        send_msg(64, 1'b0);
        t = 0;
        while (dbg_state != 2'd3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check_eq("reach_wait", 512'(dbg_state), 512'd3);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_str("abc");
        send_msg(3, 1'b1);
        wait_dv();
        check_eq("post_rst_digest", 512'(digest), 512'(ABC_DIGEST));

        check_eq("protocol_errors", 512'(proto_err), 512'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", cyc);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Byte-stream front end and block scheduler for `sha256_core_v3`. It accepts a message one byte per cycle and assembles 512-bit big-endian blocks. It applies FIPS 180-4 padding and the 64-bit length field, then issues each block to the core with the correct `first_run` flag and waits for completion. After the final block it captures the 256-bit digest. It sits between the host byte interface and the compression core and is the only agent that drives the core's `start`.

## Interface
- `CNT_W`, default 61: message byte-counter width. Bit length = count << 3, zero-extended to 64 bits.
- `clk`  in  1: single clock for the block and the core.
- `rst_n`  in  1: asynchronous, active-low reset. The core's active-high `rst` is driven from `~rst_n` at integration.
- `in_valid`  in  1: byte present on `in_data`.
- `in_data`  in  8: message byte.
- `in_last`  in  1: qualifies the final byte of a message. Zero-length messages are not supported.
- `in_ready`  out  1: byte accepted on any cycle where `in_valid && in_ready`.
- `core_start`  out  1: one-cycle start pulse to the core.
- `core_first_run`  out  1: 1 for the first block of a message, 0 for later blocks. Valid with `core_start`.
- `core_block`  out  512: block to the core. Byte 0 is `[511:504]`. Stable while `core_start` is high.
- `core_ready`  in  1: core `ready`.
- `core_hash`  in  256: core `hash_out`.
- `digest`  out  256: last completed digest. Held until the next message's digest is captured.
- `digest_valid`  out  1: one-cycle pulse when `digest` updates.
- `busy`  out  1: high from the first accepted byte of a message until the cycle `digest_valid` pulses.

## Operation
- States: FILL, PAD, START, WAIT. Reset state is FILL.
- Reset values: all outputs 0. Block buffer, byte index, byte count, `first`=1, `pend` (pending length-only or 0x80 block) = none.
- FILL:
  - `in_ready`=1.
  - Each accepted byte is written at byte index `idx`; `idx` increments and the message byte count increments.
  - If 64 bytes are now held and `in_last`=0 → START.
  - If `in_last`=1 → PAD. `cnt` = bytes held, 1..64.
- PAD (one cycle, `in_ready`=0) forms the padded block from `cnt`:
  - `cnt` ≤ 55: byte `cnt`=0x80, zeros to byte 55, bytes 56..63 = 64-bit bit length. Final block.
  - 56 ≤ `cnt` ≤ 63: byte `cnt`=0x80, zeros to byte 63. `pend`=LEN: next block is 56 zero bytes plus the length.
  - `cnt`=64: block unchanged. `pend`=PADLEN: next block is 0x80, 55 zero bytes, then the length.
  - → START.
- START (one cycle):
  - `core_start`=1 and `core_first_run`=`first`; `first` is then cleared.
  - An arm flag is cleared.
  - → WAIT.
- WAIT: sets the arm flag on the first cycle `core_ready`=0. A `core_ready`=1 sample is ignored until the arm flag is set, because `ready` stays high from the previous block until the core consumes `start`. When `core_ready`=1 with the arm flag set:
  - If `pend`≠none: load the pending block, clear `pend`, → START.
  - Else if the block was the final block: `digest`←`core_hash`, `digest_valid`←1, `first`←1, byte count←0, → FILL.
  - Else: clear buffer and `idx`, → FILL.
- Arithmetic:
  - The byte counter wraps modulo 2^`CNT_W`.
  - The length field is big-endian at bytes 56..63.
  - Buffer bytes not written are 0.
- `in_ready`=0 in PAD, START and WAIT. Upstream stalls; no byte is dropped.
- Reset mid-operation: the partial message is discarded and the core is reset simultaneously. `digest` returns to 0.

## Timing
- Byte throughput: 1 byte/cycle in FILL.
- Core latency: `core_start` at cycle S. `core_ready` is low S+1..S+66 and high at S+67. WAIT exits on the edge ending S+67, so the next state begins at S+68.
- Full non-final block: the 64th byte is accepted at cycle k, `core_start` at k+1, FILL resumes at k+69. The block period is 132 cycles at full input rate.
- Final block, `cnt` ≤ 55: last byte at k, PAD at k+1, START at k+2, `digest_valid` at k+70.
- Two-block tail (`cnt` ≥ 56): the second START follows at S+68. `digest_valid` is 68 cycles after the second START.
- `core_start` is never high for two consecutive cycles. No new START occurs before the previous block's `core_ready`.
- `digest_valid` coincides with `busy` falling. `in_ready` rises in the same cycle.

## Test plan
- "abc" (3 bytes, `in_last` on byte 2) → one start with `first_run`=1. Digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. `digest_valid` 70 cycles after the last byte.
- 56-byte "abcdbcde…nopq" → two starts with `first_run` 1 then 0. Second block is all zero except length 0x1C0. Digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 55 × 'a' vs 64 × 'a' → 1 start vs 2 starts. 64 × 'a' second block = 0x80, zeros, length 0x200. Digests match the reference model.
- 200-byte message with `in_valid` held high → `in_ready` low during each PAD/START/WAIT. `core_start` pulses are exactly one cycle wide. `first_run` pattern is 1,0,0,0. Digest matches the model.
- Back-to-back messages with `core_ready` still high from the previous message at the new START → the stale ready is ignored, the second digest is correct, and exactly one `digest_valid` pulse per message.
- `rst_n` asserted low in WAIT mid-message → all outputs 0 asynchronously. A following "abc" yields the correct digest.
